ram_access_ctrl: RTL and testbench
==================================

Name: ram_access_ctrl

Overview:
Initiator-side controller for the team's 8-bit, 256-entry chip-select RAM (cs/rw/addr/data_in/data_out strobe interface). It accepts single or burst read/write requests from a host over a valid/ready handshake. Each beat becomes a cs-strobed RAM access with stable setup. Read data returns to the host as one-cycle pulses. It sits between the CPU datapath and the RAM instance.

Parameters:
ADDR_W, 8, RAM address width; addresses wrap modulo 2^ADDR_W.
DATA_W, 8, RAM data width.
LEN_W, 4, burst length field width; beats = req_len + 1 (1..16 at default).

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-high reset.
req_valid  input  1  host request valid.
req_ready  output  1  high only in IDLE; request accepted on req_valid & req_ready.
req_rw  input  1  1 = read, 0 = write (RAM rw encoding).
req_addr  input  ADDR_W  start address.
req_len  input  LEN_W  beats minus one.
wr_valid  input  1  write data beat valid.
wr_ready  output  1  high in WAIT_WDATA only.
wr_data  input  DATA_W  write data.
rd_valid  output  1  one-cycle pulse per read beat.
rd_data  output  DATA_W  read beat data, held until the next rd_valid.
busy  output  1  high whenever state != IDLE.
err  output  1  readback mismatch flag; only functional when the optional feature is enabled.
ram_cs  output  1  RAM chip select; active high.
ram_rw  output  1  to RAM rw.
ram_addr  output  ADDR_W  to RAM addr.
ram_din  output  DATA_W  to RAM data_in.
ram_dout  input  DATA_W  from RAM data_out.

Behaviour:
- All outputs are registered. Reset values: ram_cs=0, ram_rw=1, ram_addr=0, ram_din=0, rd_valid=0, rd_data=0, busy=0, err=0, req_ready=1, wr_ready=0, state=IDLE.
- Reset asserted mid-operation:
  - ram_cs drops immediately (asynchronous).
  - The burst is abandoned; no further rd_valid.
  - The beat counter and address are cleared.
- States: IDLE, WAIT_WDATA, SETUP, STROBE, CAPTURE, RELEASE (plus VERIFY, VCAPTURE under the optional feature).
- IDLE, on accept:
  - Latch addr and beat count.
  - Go to SETUP for reads, WAIT_WDATA for writes.
  - Requests are ignored unless state is IDLE.
- WAIT_WDATA: wr_ready=1. On wr_valid, latch wr_data into ram_din and go to SETUP.
- SETUP:
  - Drive ram_addr and ram_rw with ram_cs=0.
  - Address and data are stable one full cycle before ram_cs rises.
- STROBE: ram_cs=1.
  - Write: go to RELEASE.
  - Read: go to CAPTURE.
- CAPTURE (read only):
  - ram_cs stays 1.
  - Register ram_dout into rd_data and pulse rd_valid on the next edge.
- RELEASE:
  - ram_cs=0, so every beat produces a distinct cs toggle.
  - Address increments and wraps 0xFF -> 0x00.
  - If beats remain, go to SETUP (read) or WAIT_WDATA (write); otherwise go to IDLE.
- Read beat: 4 cycles. First rd_valid appears 4 clk after the accept edge. Back-to-back read beats are 4 cycles apart.
- Write beat: 3 cycles after wr_valid is accepted. Stalls in WAIT_WDATA indefinitely with ram_cs=0.
- ram_rw and ram_addr never change while ram_cs=1.
- req_len=0 performs exactly one beat.

Optional Feature:
Macro RAM_ACCESS_READBACK_EN.
- Defined: every write beat inserts VERIFY and VCAPTURE after RELEASE.
  - VERIFY: ram_rw=1, ram_cs=1 at the same address.
  - VCAPTURE: compare ram_dout with the written data. On mismatch, set err.
  - err is sticky until the next accepted request clears it.
  - A write beat becomes 5 cycles. The address increment moves to after VCAPTURE.
  - No rd_valid is produced for verify reads.
- Undefined: the verify states are absent and err is tied 0.

Decomposition:
- Package ram_access_pkg holds:
  - State enum.
  - RW_READ=1 and RW_WRITE=0 constants.
  - Default ADDR_W, DATA_W and LEN_W.
- One natural sub-module, ram_burst_counter:
  - Loads address and beat count on accept.
  - Increments and wraps the address, decrements the count.
  - Outputs last_beat.

Test Plan:
- Single write then read: write 0xA5 to addr 0x10, then read addr 0x10 -> one rd_valid with rd_data=0xA5, 4 clk after the accept edge. ram_cs rises exactly once per beat.
- Burst wrap: write burst addr 0xFE, req_len=3, data 1,2,3,4; then read the same burst -> rd_data 1,2,3,4 from addrs FE,FF,00,01; rd_valid pulses 4 cycles apart.
- Write stall: hold wr_valid low for 10 cycles mid-burst -> ram_cs stays 0, busy=1, the burst resumes correctly.
- Protocol check: an assertion over all tests -> ram_addr and ram_rw are constant while ram_cs=1, and ram_cs is never high two beats without a low cycle between.
- Reset mid-burst: assert reset during STROBE of beat 2 of 4 -> ram_cs=0 immediately, no further rd_valid, req_ready=1 after release.
- With RAM_ACCESS_READBACK_EN: force ram_dout mismatch (stubbed RAM) on a write -> err=1, held until the next accepted request; a matching write leaves err=0.

Source files
------------

// File: rtl/ram_access_pkg.sv
// Shared types and constants for the chip-select RAM access controller.
// Optional feature macro: RAM_ACCESS_READBACK_EN (adds the write readback states).
package ram_access_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_LEN_W  = 4;

  // RAM rw pin encoding
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_WDATA = 3'd1,
    ST_SETUP      = 3'd2,
    ST_STROBE     = 3'd3,
    ST_CAPTURE    = 3'd4,
    ST_RELEASE    = 3'd5
`ifdef RAM_ACCESS_READBACK_EN
    ,
    ST_VERIFY     = 3'd6,
    ST_VCAPTURE   = 3'd7
`endif
  } state_t;

endpackage

// File: rtl/ram_burst_counter.sv
// Burst address/beat bookkeeping: loads on accept, steps once per finished beat.
// Address wraps modulo 2^ADDR_W; last_beat is high while on the final beat.
module ram_burst_counter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last_beat
);

  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_remain;

  // Load on accept; advance address and consume one beat per step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr   <= '0;
      r_remain <= '0;
    end else if (i_load) begin
      r_addr   <= i_addr;
      r_remain <= i_len;
    end else if (i_step) begin
      r_addr <= r_addr + ADDR_W'(1);
      if (r_remain != '0) begin
        r_remain <= r_remain - LEN_W'(1);
      end
    end
  end

  assign o_addr      = r_addr;
  assign o_last_beat = (r_remain == '0);

endmodule

// File: rtl/ram_access_ctrl.sv
// Host-side controller for the cs/rw strobe RAM: single or burst reads/writes
// over valid/ready, one cs pulse per beat with a full setup cycle before cs.
// Optional feature macro: RAM_ACCESS_READBACK_EN (verify every written beat, sticky err).
module ram_access_ctrl
  import ram_access_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              err,
  output logic              ram_cs,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  state_t            r_state;
  logic              r_is_read;
  logic              r_ram_cs;
  logic              r_ram_rw;
  logic [DATA_W-1:0] r_ram_din;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_busy;
  logic              r_req_ready;
  logic              r_wr_ready;

  logic              w_accept;
  logic              w_beat_done;
  logic              w_last_beat;
  logic [ADDR_W-1:0] w_addr;

  // Requests are only taken while idle
  assign w_accept = (r_state == ST_IDLE) && req_valid;

  // A beat finishes after RELEASE, or after the verify read when readback is on
`ifdef RAM_ACCESS_READBACK_EN
  assign w_beat_done = ((r_state == ST_RELEASE) && r_is_read) || (r_state == ST_VCAPTURE);
`else
  assign w_beat_done = (r_state == ST_RELEASE);
`endif

  ram_burst_counter #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_burst_counter (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_accept),
    .i_step      (w_beat_done),
    .i_addr      (req_addr),
    .i_len       (req_len),
    .o_addr      (w_addr),
    .o_last_beat (w_last_beat)
  );

`ifdef RAM_ACCESS_READBACK_EN
  logic r_err;
`endif

  // Access sequencer: state plus all registered host/RAM outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_is_read   <= RW_READ;
      r_ram_cs    <= 1'b0;
      r_ram_rw    <= RW_READ;
      r_ram_din   <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_busy      <= 1'b0;
      r_req_ready <= 1'b1;
      r_wr_ready  <= 1'b0;
`ifdef RAM_ACCESS_READBACK_EN
      r_err       <= 1'b0;
`endif
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_is_read   <= (req_rw == RW_READ);
            r_ram_rw    <= req_rw;
            r_busy      <= 1'b1;
            r_req_ready <= 1'b0;
`ifdef RAM_ACCESS_READBACK_EN
            r_err       <= 1'b0;
`endif
            if (req_rw == RW_READ) begin
              r_state <= ST_SETUP;
            end else begin
              r_state    <= ST_WAIT_WDATA;
              r_wr_ready <= 1'b1;
            end
          end
        end
        ST_WAIT_WDATA: begin
          if (wr_valid) begin
            r_ram_din  <= wr_data;
            r_wr_ready <= 1'b0;
            r_state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_ram_cs <= 1'b1;
          r_state  <= ST_STROBE;
        end
        ST_STROBE: begin
          if (r_is_read) begin
            r_state <= ST_CAPTURE;
          end else begin
            r_ram_cs <= 1'b0;
            r_state  <= ST_RELEASE;
          end
        end
        ST_CAPTURE: begin
          r_rd_data  <= ram_dout;
          r_rd_valid <= 1'b1;
          r_ram_cs   <= 1'b0;
          r_state    <= ST_RELEASE;
        end
        ST_RELEASE: begin
`ifdef RAM_ACCESS_READBACK_EN
          if (!r_is_read) begin
            r_ram_cs <= 1'b1;
            r_ram_rw <= RW_READ;
            r_state  <= ST_VERIFY;
          end
`endif
        end
`ifdef RAM_ACCESS_READBACK_EN
        ST_VERIFY: begin
          r_state <= ST_VCAPTURE;
        end
        ST_VCAPTURE: begin
          if (ram_dout != r_ram_din) begin
            r_err <= 1'b1;
          end
          r_ram_cs <= 1'b0;
          r_ram_rw <= RW_WRITE;
        end
`endif
        default: begin
          r_ram_cs <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase

      // End of beat: next beat or back to idle
      if (w_beat_done) begin
        if (w_last_beat) begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_req_ready <= 1'b1;
        end else if (r_is_read) begin
          r_state <= ST_SETUP;
        end else begin
          r_state    <= ST_WAIT_WDATA;
          r_wr_ready <= 1'b1;
        end
      end
    end
  end

`ifdef RAM_ACCESS_READBACK_EN
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign req_ready = r_req_ready;
  assign wr_ready  = r_wr_ready;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign busy      = r_busy;
  assign ram_cs    = r_ram_cs;
  assign ram_rw    = r_ram_rw;
  assign ram_addr  = w_addr;
  assign ram_din   = r_ram_din;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl with a stubbed RAM and a memory-array reference model.
// Honours RAM_ACCESS_READBACK_EN when defined for the build.
module tb_ram_access_ctrl;
  import ram_access_pkg::*;

`ifdef RAM_ACCESS_READBACK_EN
  localparam int WB        = 5;
  localparam int WR_RISES  = 2;
  localparam bit READBACK  = 1'b1;
`else
  localparam int WB        = 3;
  localparam int WR_RISES  = 1;
  localparam bit READBACK  = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid, req_ready, req_rw;
  logic [7:0] req_addr;
  logic [3:0] req_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy, err;
  logic       ram_cs, ram_rw;
  logic [7:0] ram_addr, ram_din, ram_dout;

  ram_access_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .busy      (busy),
    .err       (err),
    .ram_cs    (ram_cs),
    .ram_rw    (ram_rw),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;

  // Stubbed RAM; corrupt flips read data to provoke readback mismatches
  logic [7:0] mem       [256];
  logic [7:0] model_mem [256];
  logic       corrupt = 1'b0;
  assign ram_dout = mem[ram_addr] ^ (corrupt ? 8'hFF : 8'h00);
  always @(posedge clk) if (ram_cs && ram_rw == RW_WRITE) mem[ram_addr] <= ram_din;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] wbuf [16];
  logic [7:0] exp_rd = 8'h00;
  logic       exp_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Protocol monitor: cs never held across beats, addr/rw frozen while cs high
  logic       prev_cs = 1'b0;
  logic       prev_rw = 1'b1;
  logic [7:0] prev_addr = 8'h00;
  int         cs_run = 0;
  int         cs_rises = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (ram_cs && prev_cs) begin
        chk("cs_addr_stable", 32'(ram_addr), 32'(prev_addr));
        chk("cs_rw_stable", 32'(ram_rw), 32'(prev_rw));
      end
      if (ram_cs && !prev_cs) cs_rises++;
      cs_run = ram_cs ? cs_run + 1 : 0;
      if (ram_cs) chk("cs_run_le2", 32'(cs_run <= 2), 32'd1);
    end
    prev_cs   = ram_cs;
    prev_rw   = ram_rw;
    prev_addr = ram_addr;
  end

  task automatic do_write(input logic [7:0] a, input int len, input int stall_beat,
                          input int stall_n, input bit bad);
    int         rises0;
    logic [7:0] addr;
    rises0 = cs_rises;
    addr   = a;
    @(negedge clk);
    chk("wr_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_rw = RW_WRITE; req_addr = a; req_len = 4'(len);
    @(negedge clk);
    req_valid = 1'b0; req_addr = 8'($urandom);
    exp_err   = 1'b0;
    chk("wr_busy", 32'(busy), 32'd1);
    chk("wr_err_clear", 32'(err), 32'(exp_err));
    for (int b = 0; b <= len; b++) begin
      if (b == stall_beat) begin
        for (int s = 0; s < stall_n; s++) begin
          chk("stall_cs", 32'(ram_cs), 32'd0);
          chk("stall_busy", 32'(busy), 32'd1);
          chk("stall_wr_ready", 32'(wr_ready), 32'd1);
          @(negedge clk);
        end
      end
      chk("wr_ready", 32'(wr_ready), 32'd1);
      wr_valid = 1'b1; wr_data = wbuf[b]; corrupt = bad;
      @(negedge clk);
      wr_valid = 1'b0; wr_data = 8'($urandom);
      chk("wr_setup_cs", 32'(ram_cs), 32'd0);
      chk("wr_din", 32'(ram_din), 32'(wbuf[b]));
      chk("wr_addr", 32'(ram_addr), 32'(addr));
      @(negedge clk);
      chk("wr_strobe_cs", 32'(ram_cs), 32'd1);
      chk("wr_strobe_rw", 32'(ram_rw), 32'(RW_WRITE));
      for (int k = 0; k < WB - 1; k++) @(negedge clk);
      model_mem[addr] = wbuf[b];
      if (bad && READBACK) exp_err = 1'b1;
      addr = addr + 8'd1;
    end
    corrupt = 1'b0;
    chk("wr_done_ready", 32'(req_ready), 32'd1);
    chk("wr_done_busy", 32'(busy), 32'd0);
    chk("wr_done_err", 32'(err), 32'(exp_err));
    chk("wr_cs_rises", 32'(cs_rises - rises0), 32'((len + 1) * WR_RISES));
  endtask

  // rst_at > 0 asserts reset in that cycle after the accept edge and abandons the burst
  task automatic do_read(input logic [7:0] a, input int len, input int rst_at);
    int         rises0;
    logic [7:0] addr;
    bit         aborted;
    rises0  = cs_rises;
    addr    = a;
    aborted = 1'b0;
    @(negedge clk);
    chk("rd_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_rw = RW_READ; req_addr = a; req_len = 4'(len);
    for (int k = 1; k <= 4 * (len + 1) && !aborted; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0; req_addr = 8'($urandom);
        exp_err   = 1'b0;
        chk("rd_err_clear", 32'(err), 32'(exp_err));
      end
      if (k == rst_at) begin
        reset = 1'b1;
        #1;
        chk("rst_cs_async", 32'(ram_cs), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        exp_rd  = 8'h00;
        aborted = 1'b1;
      end else begin
        chk("rd_valid", 32'(rd_valid), 32'(k % 4 == 0));
        chk("rd_busy", 32'(busy), 32'd1);
        case (k % 4)
          1: begin
            chk("rd_setup_cs", 32'(ram_cs), 32'd0);
            chk("rd_addr", 32'(ram_addr), 32'(addr));
          end
          2: begin
            chk("rd_strobe_cs", 32'(ram_cs), 32'd1);
            chk("rd_strobe_rw", 32'(ram_rw), 32'(RW_READ));
            chk("rd_data_hold", 32'(rd_data), 32'(exp_rd));
          end
          0: begin
            exp_rd = model_mem[addr];
            chk("rd_data", 32'(rd_data), 32'(exp_rd));
            addr = addr + 8'd1;
          end
          default: ;
        endcase
      end
    end
    if (!aborted) begin
      @(negedge clk);
      chk("rd_done_ready", 32'(req_ready), 32'd1);
      chk("rd_done_busy", 32'(busy), 32'd0);
      chk("rd_done_valid", 32'(rd_valid), 32'd0);
      chk("rd_cs_rises", 32'(cs_rises - rises0), 32'(len + 1));
    end
  endtask

  initial begin
    int a, len, stall_beat;
    req_valid = 1'b0; req_rw = RW_READ; req_addr = 8'h00; req_len = 4'h0;
    wr_valid = 1'b0; wr_data = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[i]       = 8'($urandom);
      model_mem[i] = mem[i];
    end
    repeat (3) @(negedge clk);
    chk("reset_cs", 32'(ram_cs), 32'd0);
    chk("reset_rw", 32'(ram_rw), 32'd1);
    chk("reset_addr", 32'(ram_addr), 32'd0);
    chk("reset_din", 32'(ram_din), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_wr_ready", 32'(wr_ready), 32'd0);
    reset = 1'b0;

    // Single write then read
    wbuf[0] = 8'hA5;
    do_write(8'h10, 0, -1, 0, 1'b0);
    do_read(8'h10, 0, 0);

    // Burst across the address wrap
    for (int i = 0; i < 4; i++) wbuf[i] = 8'(i + 1);
    do_write(8'hFE, 3, -1, 0, 1'b0);
    do_read(8'hFE, 3, 0);

    // Host stalls write data mid-burst
    for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
    do_write(8'h40, 3, 2, 10, 1'b0);
    do_read(8'h40, 3, 0);

    // Readback mismatch: err sticky until the next accepted request
    wbuf[0] = 8'h3C;
    do_write(8'h80, 0, -1, 0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("err_sticky", 32'(err), 32'(exp_err));
    end
    wbuf[0] = 8'hC3;
    do_write(8'h81, 0, -1, 0, 1'b0);
    do_read(8'h80, 1, 0);

    // Randomized bursts
    for (int it = 0; it < 12; it++) begin
      a          = int'($urandom_range(0, 255));
      len        = (it % 4 == 3) ? 15 : int'($urandom_range(0, 5));
      stall_beat = int'($urandom_range(0, 6));
      for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
      do_write(8'(a), len, stall_beat, int'($urandom_range(1, 4)), 1'b0);
      do_read(8'(a), len, 0);
      do_read(8'($urandom), int'($urandom_range(0, 3)), 0);
    end

    // Reset during STROBE of beat 2 of 4
    do_read(8'h20, 3, 6);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("post_rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("post_rst_cs", 32'(ram_cs), 32'd0);
    end
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    do_read(8'h20, 3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
